// File: rtl/ga_pkg.sv
// Shared GA constants, derived bus widths, selection FSM states and list entry type.
package ga_pkg;

  localparam int unsigned NUM_PATHS = 50;
  localparam int unsigned NUM_SEL   = 10;
  localparam int unsigned PATH_W    = 150;
  localparam int unsigned FIT_W     = 16;

  localparam int unsigned POP_W     = NUM_PATHS * PATH_W;
  localparam int unsigned POP_FIT_W = NUM_PATHS * FIT_W;
  localparam int unsigned SEL_W     = NUM_SEL * PATH_W;
  localparam int unsigned SEL_FIT_W = NUM_SEL * FIT_W;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = $clog2(NUM_PATHS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } sel_state_e;

  // One held list slot: a path and its fitness.
  typedef struct packed {
    logic [PATH_W-1:0] path;
    logic [FIT_W-1:0]  fit;
  } sel_entry_t;

endpackage

// File: rtl/sel_insert.sv
// Sorted-list insertion step: computes the stable insertion position of one
// candidate and returns the updated best-first list and entry count.
// With SELECTION_DEDUP_EN defined, a candidate whose path matches any held
// path is discarded.
module sel_insert
  import ga_pkg::*;
(
  input  sel_entry_t [NUM_SEL-1:0] list_i,
  input  logic       [CNT_W-1:0]   count_i,
  input  sel_entry_t               cand_i,
  output sel_entry_t [NUM_SEL-1:0] list_c_o,
  output logic       [CNT_W-1:0]   count_c_o
);

  logic [CNT_W-1:0]         pos_c;
  logic                     dup_c;
  logic                     ins_c;
  sel_entry_t [NUM_SEL-1:0] shift_c;

  // Position = held entries with fitness <= candidate (ties keep earlier index first).
  always_comb begin
    pos_c = '0;
    dup_c = 1'b0;
    for (int unsigned j = 0; j < NUM_SEL; j++) begin
      if ((CNT_W'(j) < count_i) && (list_i[j].fit <= cand_i.fit)) begin
        pos_c = pos_c + CNT_W'(1);
      end
`ifdef SELECTION_DEDUP_EN
      if ((CNT_W'(j) < count_i) && (list_i[j].path == cand_i.path)) begin
        dup_c = 1'b1;
      end
`endif
    end
  end

  assign ins_c   = (pos_c < CNT_W'(NUM_SEL)) && !dup_c;
  // shift_c[j] holds list_i[j-1]; the last entry falls off the end.
  assign shift_c = {list_i[NUM_SEL-2:0], sel_entry_t'('0)};

  // Build the updated list: keep above p, candidate at p, shifted below p.
  always_comb begin
    list_c_o  = list_i;
    count_c_o = count_i;
    if (ins_c) begin
      for (int unsigned j = 0; j < NUM_SEL; j++) begin
        if (CNT_W'(j) < pos_c) begin
          list_c_o[j] = list_i[j];
        end else if (CNT_W'(j) == pos_c) begin
          list_c_o[j] = cand_i;
        end else begin
          list_c_o[j] = shift_c[j];
        end
      end
      count_c_o = (count_i == CNT_W'(NUM_SEL)) ? count_i : count_i + CNT_W'(1);
    end
  end

endmodule

// File: rtl/selection.sv
// GA selection stage: captures a population on start, scans one candidate per
// cycle into a sorted best-first list of NUM_SEL entries, then publishes the
// list with a one-cycle done pulse.
// Optional duplicate-path rejection: define SELECTION_DEDUP_EN.
module selection
  import ga_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [POP_W-1:0]     population,
  input  logic [POP_FIT_W-1:0] fitness,
  output logic [SEL_W-1:0]     sel_population,
  output logic [SEL_FIT_W-1:0] sel_fitness,
  output logic [CNT_W-1:0]     sel_count,
  output logic                 busy,
  output logic                 done
);

  sel_state_e                             state_q, state_d;
  logic       [IDX_W-1:0]                 idx_q, idx_d;
  logic       [NUM_PATHS-1:0][PATH_W-1:0] pop_q, pop_d;
  logic       [NUM_PATHS-1:0][FIT_W-1:0]  fit_q, fit_d;
  sel_entry_t [NUM_SEL-1:0]               list_q, list_d;
  logic       [CNT_W-1:0]                 cnt_q, cnt_d;
  logic       [NUM_SEL-1:0][PATH_W-1:0]   sel_pop_q, sel_pop_d;
  logic       [NUM_SEL-1:0][FIT_W-1:0]    sel_fit_q, sel_fit_d;
  logic       [CNT_W-1:0]                 sel_cnt_q, sel_cnt_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  sel_entry_t                             cand_c;
  sel_entry_t [NUM_SEL-1:0]               ins_list_c;
  logic       [CNT_W-1:0]                 ins_cnt_c;

  // Path 0 sits in the top slice of the captured vectors.
  always_comb begin
    cand_c.path = pop_q[IDX_W'(NUM_PATHS-1) - idx_q];
    cand_c.fit  = fit_q[IDX_W'(NUM_PATHS-1) - idx_q];
  end

  sel_insert u_sel_insert (
    .list_i    (list_q),
    .count_i   (cnt_q),
    .cand_i    (cand_c),
    .list_c_o  (ins_list_c),
    .count_c_o (ins_cnt_c)
  );

  // Next-state and datapath updates for IDLE / SCAN / WRITE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop_d     = pop_q;
    fit_d     = fit_q;
    list_d    = list_q;
    cnt_d     = cnt_q;
    sel_pop_d = sel_pop_q;
    sel_fit_d = sel_fit_q;
    sel_cnt_d = sel_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pop_d   = population;
          fit_d   = fitness;
          list_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        list_d = ins_list_c;
        cnt_d  = ins_cnt_c;
        if (idx_q == IDX_W'(NUM_PATHS-1)) begin
          state_d = WRITE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      WRITE: begin
        for (int unsigned j = 0; j < NUM_SEL; j++) begin
          sel_pop_d[NUM_SEL-1-j] = list_q[j].path;
          sel_fit_d[NUM_SEL-1-j] = list_q[j].fit;
        end
        sel_cnt_d = cnt_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pop_q     <= '0;
      fit_q     <= '0;
      list_q    <= '0;
      cnt_q     <= '0;
      sel_pop_q <= '0;
      sel_fit_q <= '0;
      sel_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pop_q     <= pop_d;
      fit_q     <= fit_d;
      list_q    <= list_d;
      cnt_q     <= cnt_d;
      sel_pop_q <= sel_pop_d;
      sel_fit_q <= sel_fit_d;
      sel_cnt_q <= sel_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel_population = sel_pop_q;
  assign sel_fitness    = sel_fit_q;
  assign sel_count      = sel_cnt_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
